regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Arbitrates the single register-file write port between two writeback requesters.
- Requester 0: the main pipeline writeback.
- Requester 1: the long-latency unit writeback (load/mul-div).
Uses a valid/ready handshake per requester and fixed priority to requester 0, with an anti-starvation counter that forces a grant to requester 1. Drives the register file's we/wa/wd pins through registered outputs.

Parameters:
- XLEN, 32, data width of wd and requester data.
- MAX_WAIT, 4, cycles requester 1 may be stalled before a forced grant (must be >= 1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 has a write.
- r0_addr  in  5  requester 0 destination register.
- r0_data  in  XLEN  requester 0 write data.
- r0_ready  out  1  requester 0 write accepted this cycle.
- r1_valid  in  1  requester 1 has a write.
- r1_addr  in  5  requester 1 destination register.
- r1_data  in  XLEN  requester 1 write data.
- r1_ready  out  1  requester 1 write accepted this cycle.
- rf_we  out  1  register file write enable.
- rf_wa  out  5  register file write address.
- rf_wd  out  XLEN  register file write data.
- conflict_cnt  out  32  cycles with both requesters valid (see Optional Feature).

Behaviour:
- Handshake: a transfer occurs when valid && ready in the same cycle. Once valid is raised, the requester holds valid/addr/data stable until ready.
- Ready is combinational from the current valid inputs and wait_cnt:
  - force = r1_valid && (wait_cnt == MAX_WAIT).
  - r0_ready = !force.
  - r1_ready = force || !r0_valid.
- Exactly one transfer per cycle at most; both readies are never high while both valids are high.
- wait_cnt, width $clog2(MAX_WAIT+1), reset 0:
  - cleared when r1 transfers or when r1_valid = 0;
  - otherwise incremented, saturating at MAX_WAIT.
- Arbiter states:
  - IDLE: no valid.
  - GRANT0: r0 wins.
  - GRANT1: r1 wins because r0 is idle.
  - FORCE1: wait_cnt == MAX_WAIT.
  - States are derived from valids and wait_cnt; no extra sequencing state.
- Output timing: rf_we/rf_wa/rf_wd are registered, so a write transferring in cycle N appears on the outputs in cycle N+1. The register file commits it at the end of N+1.
  - rf_we = 1 only if a transfer occurred and its addr != 0.
  - Writes to x0 are accepted (ready high) but produce rf_we = 0.
  - rf_wa/rf_wd load the winner's addr/data on every transfer (including x0) and hold their value otherwise.
- Same-address conflict (both valid, same addr, no force): r0 is written in cycle N+1, r1 in a later cycle. Final register value is r1_data; ordering follows grant order.
- Reset values: rf_we = 0, rf_wa = 0, rf_wd = 0, wait_cnt = 0, conflict_cnt = 0.
- During reset: r0_ready = r1_ready = 0 and no transfer occurs.
- Reset asserted mid-operation: any registered write not yet presented is dropped (rf_we = 0 in the cycle after reset asserts). Requesters re-present after reset deasserts.
- Starvation bound: with r0_valid held high continuously, r1 is granted no later than MAX_WAIT+1 cycles after raising r1_valid.

Optional Feature:
Macro: WB_ARB_STATS_EN.
- Defined: conflict_cnt increments by 1 every cycle with r0_valid && r1_valid and rst = 0, wrapping at 2^32.
- Undefined: conflict_cnt is tied to 0 and no counter logic is present.
- The port exists in both builds.

Test Plan:
- r0 writes x5 = 0xDEADBEEF, r1 idle -> r0_ready = 1 in cycle N; cycle N+1: rf_we = 1, rf_wa = 5, rf_wd = 0xDEADBEEF.
- r1 writes x0 = 0x1234, r0 idle -> r1_ready = 1; next cycle rf_we = 0, rf_wa = 0, rf_wd = 0x1234.
- Both valid, r0 = x3 = 0x11 and r1 = x3 = 0x22, r0 drops after one write -> rf writes 0x11 then 0x22 in consecutive cycles; final x3 = 0x22.
- r0_valid held high with new addresses every cycle, r1_valid raised at cycle 0, MAX_WAIT = 4 -> r1_ready low in cycles 0-3, high in cycle 4, r0_ready low in cycle 4; wait_cnt returns to 0 in cycle 5.
- Transfer in cycle N, rst = 1 in cycle N+1 -> rf_we = 0 in cycle N+2, both readies 0 while rst is high; normal operation resumes the cycle after rst falls.
- With WB_ARB_STATS_EN, both valid for 6 cycles -> conflict_cnt = 6; without the macro -> conflict_cnt = 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates the single register-file write port between the main
//   pipeline writeback (requester 0) and the long-latency unit writeback
//   (requester 1). Requester 0 has fixed priority. A wait counter forces a
//   grant to requester 1 once it has been stalled MAX_WAIT cycles.
//
// Handshake: a transfer happens in a cycle where valid && ready are both
//   high. A requester that raises valid holds valid/addr/data stable until
//   it sees ready. Ready is combinational from the valids and wait_cnt, and
//   both readies are held low while rst is high.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   r0_valid/addr/data/ready requester 0 (main pipeline writeback)
//   r1_valid/addr/data/ready requester 1 (load / mul-div writeback)
//   rf_we/rf_wa/rf_wd        registered register-file write pins
//   conflict_cnt             cycles with both requesters valid
//   dbg_state                current arbiter state (IDLE/GRANT0/GRANT1/FORCE1)
//
// Optional build macro: WB_ARB_STATS_EN enables the conflict counter;
//   without it conflict_cnt is tied to 0.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_valid,
  input  logic [4:0]      r0_addr,
  input  logic [XLEN-1:0] r0_data,
  output logic            r0_ready,
  input  logic            r1_valid,
  input  logic [4:0]      r1_addr,
  input  logic [XLEN-1:0] r1_data,
  output logic            r1_ready,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     conflict_cnt,
  output logic [1:0]      dbg_state
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    FORCE1 = 2'd3
  } arb_state_t;

  arb_state_t      state;
  logic [WW-1:0]   wait_cnt;
  logic            tx0;
  logic            tx1;
  logic            tx;
  logic [4:0]      win_addr;
  logic [XLEN-1:0] win_data;

  // The state is a pure function of the valids and wait_cnt; wait_cnt is
  // the only sequencing register behind it.
  always_comb begin
    state = IDLE;
    if (r1_valid && (wait_cnt == MAX_W)) state = FORCE1;
    else if (r0_valid)                   state = GRANT0;
    else if (r1_valid)                   state = GRANT1;
  end

  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (!rst) begin
      r0_ready = (state != FORCE1);
      r1_ready = (state == FORCE1) || !r0_valid;
    end
  end

  assign tx0      = r0_valid && r0_ready;
  assign tx1      = r1_valid && r1_ready;
  assign tx       = tx0 || tx1;
  // tx0 and tx1 are mutually exclusive, so selecting on tx1 is enough.
  assign win_addr = tx1 ? r1_addr : r0_addr;
  assign win_data = tx1 ? r1_data : r0_data;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_wa    <= 5'd0;
      rf_wd    <= '0;
      wait_cnt <= '0;
    end else begin
      // Writes to x0 are accepted and update wa/wd but never assert we.
      rf_we <= tx && (win_addr != 5'd0);
      if (tx) begin
        rf_wa <= win_addr;
        rf_wd <= win_data;
      end
      if (!r1_valid || tx1)      wait_cnt <= '0;
      else if (wait_cnt != MAX_W) wait_cnt <= wait_cnt + WW'(1);
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] conflict_q;
  always_ff @(posedge clk) begin
    if (rst)                        conflict_q <= 32'd0;
    else if (r0_valid && r1_valid) conflict_q <= conflict_q + 32'd1;
  end
  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 32'd0;
`endif

endmodule
